axis_vc_queue: RTL and testbench

AXIS_VC_QUEUE -- requirements
Module: axis_vc_queue

---
 rtl/axis_pkg.sv | 25 ++
 rtl/axis_vc_queue_pkg.sv | 6 +
 rtl/fifo.sv | 55 +++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/axis_vc_queue.sv | 129 ++++++++++++
 tb/tb_axis_vc_queue.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream beat types used by the VC queue and the router.
// The widths here define the wire format that every block instantiating these types must agree on.
package axis_pkg;
    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_ID_W   = 4;
    localparam int AXIS_DEST_W = 4;
    localparam int AXIS_USER_W = 4;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] TDATA;
        logic [AXIS_ID_W-1:0]   TID;
        logic [AXIS_DEST_W-1:0] TDEST;
        logic [AXIS_USER_W-1:0] TUSER;
        logic                   TLAST;
    } axis_data_t;

    typedef struct packed {
        logic       TVALID;
        axis_data_t data;
    } axis_mosi_t;

    typedef struct packed {
        logic TREADY;
    } axis_miso_t;
endpackage

// File: rtl/axis_vc_queue_pkg.sv
// Width helpers for the VC queue and its arbiter.
package axis_vc_queue_pkg;
    function automatic int vc_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction
endpackage

// File: rtl/fifo.sv
// Generic circular FIFO with an occupancy counter. Latency: head visible the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; head data is combinational.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_i && !pop_i)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = cnt_q;
    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; search starts just after the last advanced grant.
// Latency: grant is combinational from req; priority moves only on advance_i.
module rr_arbiter
    import axis_vc_queue_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = vc_width(N);

    logic [PW-1:0] prio_q, prio_d;
    logic          found;
    int            idx;

    always_comb begin
        grant_o = '0;
        prio_d  = prio_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(prio_q) + i) % N;
            if (!found && req_i[idx[PW-1:0]]) begin
                found                = 1'b1;
                grant_o[idx[PW-1:0]] = 1'b1;
                if (advance_i) prio_d = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prio_q <= '0;
        else       prio_q <= prio_d;
    end
endmodule

// File: rtl/axis_vc_queue.sv
// Per-VC AXI-Stream queue with packet-locked round-robin egress. Latency: 1 cycle ingress to egress valid.
// Backpressure: ingress TREADY = target VC not full; egress is one registered stage held while !TREADY.
module axis_vc_queue
    import axis_pkg::*;
    import axis_vc_queue_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int DEST_WIDTH    = 4,
    parameter int USER_WIDTH    = 4,
    parameter int BUFFER_LENGTH = 16,
    parameter int CHANNEL_COUNT = 4,
    localparam int VC_W  = vc_width(CHANNEL_COUNT),
    localparam int LVL_W = $clog2(BUFFER_LENGTH) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  axis_mosi_t                           in_mosi_i,
    input  logic [VC_W-1:0]                      in_vc_i,
    output axis_miso_t                           in_miso_o,
    output axis_mosi_t                           out_mosi_o,
    output logic [VC_W-1:0]                      out_vc_o,
    input  axis_miso_t                           out_miso_i,
    output logic [CHANNEL_COUNT-1:0][LVL_W-1:0]  level_o,
    output logic [CHANNEL_COUNT-1:0]             full_o,
    output logic [CHANNEL_COUNT-1:0]             empty_o
);
    // Width parameters must match the axis_pkg beat layout.
    localparam int BEAT_W = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    logic [BEAT_W-1:0]        head_dat [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] push, pop, req, grant;
    logic                     vc_ok, in_rdy, stage_free, load;
    axis_data_t               sel_dat;
    logic [VC_W-1:0]          sel_vc;

    logic                     out_vld_q, out_vld_d;
    axis_data_t               out_dat_q, out_dat_d;
    logic [VC_W-1:0]          out_vc_q, out_vc_d;
    logic                     lock_vld_q, lock_vld_d;
    logic [VC_W-1:0]          lock_vc_q, lock_vc_d;

    assign vc_ok             = ({1'b0, in_vc_i} < (VC_W+1)'(CHANNEL_COUNT));
    assign in_rdy            = vc_ok && !full_o[in_vc_i];
    assign in_miso_o.TREADY  = in_rdy;

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_vc
        assign push[c] = in_mosi_i.TVALID && in_rdy && (in_vc_i == VC_W'(c));
        // A locked packet masks every other channel, even while its own queue runs dry.
        assign req[c]  = !empty_o[c] && (!lock_vld_q || (lock_vc_q == VC_W'(c)));
        assign pop[c]  = load && grant[c];

        fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (BUFFER_LENGTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .push_i     (push[c]),
            .push_dat_i (in_mosi_i.data),
            .pop_i      (pop[c]),
            .head_dat_o (head_dat[c]),
            .level_o    (level_o[c]),
            .full_o     (full_o[c]),
            .empty_o    (empty_o[c])
        );
    end

    rr_arbiter #(
        .N (CHANNEL_COUNT)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req),
        .advance_i (load),
        .grant_o   (grant)
    );

    always_comb begin
        sel_dat = head_dat[0];
        sel_vc  = '0;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            if (grant[c]) begin
                sel_dat = head_dat[c];
                sel_vc  = VC_W'(c);
            end
        end
    end

    assign stage_free = !out_vld_q || out_miso_i.TREADY;
    assign load       = stage_free && (|grant);

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_vc_d   = out_vc_q;
        lock_vld_d = lock_vld_q;
        lock_vc_d  = lock_vc_q;
        if (stage_free) out_vld_d = |grant;
        if (load) begin
            out_dat_d  = sel_dat;
            out_vc_d   = sel_vc;
            lock_vld_d = !sel_dat.TLAST;
            lock_vc_d  = sel_vc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld_q  <= 1'b0;
            out_vc_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_vc_q  <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_vc_q   <= out_vc_d;
            lock_vld_q <= lock_vld_d;
            lock_vc_q  <= lock_vc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        out_dat_q <= out_dat_d;
    end

    assign out_mosi_o.TVALID = out_vld_q;
    assign out_mosi_o.data   = out_dat_q;
    assign out_vc_o          = out_vc_q;
endmodule

// File: tb/tb_axis_vc_queue.sv
// Directed bench for axis_vc_queue with default parameters (4 VCs, 16-beat buffers).
module tb_axis_vc_queue;
    import axis_pkg::*;

    typedef struct packed {
        logic [1:0]  vc;
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    axis_mosi_t      in_mosi;
    logic [1:0]      in_vc;
    axis_miso_t      in_miso;
    axis_mosi_t      out_mosi;
    logic [1:0]      out_vc;
    axis_miso_t      out_miso;
    logic [3:0][4:0] level;
    logic [3:0]      full;
    logic [3:0]      empty;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];

    axis_vc_queue dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_mosi_i  (in_mosi),
        .in_vc_i    (in_vc),
        .in_miso_o  (in_miso),
        .out_mosi_o (out_mosi),
        .out_vc_o   (out_vc),
        .out_miso_i (out_miso),
        .level_o    (level),
        .full_o     (full),
        .empty_o    (empty)
    );

    always #5 clk = ~clk;

    // Egress beats accepted at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_mosi.TVALID && out_miso.TREADY)
            q.push_back('{vc: out_vc, d: out_mosi.data.TDATA, last: out_mosi.data.TLAST});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] vc, input logic [31:0] d, input logic last);
        in_mosi.TVALID     = v;
        in_vc              = vc;
        in_mosi.data.TDATA = d;
        in_mosi.data.TID   = '0;
        in_mosi.data.TDEST = '0;
        in_mosi.data.TUSER = '0;
        in_mosi.data.TLAST = last;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        out_miso.TREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_mosi.TVALID !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", out_mosi.TVALID); end
        checks++; if (out_vc !== 2'd0) begin errors++; $display("FAIL rst_vc got %0d want 0", out_vc); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got %h want 0", level); end
        checks++; if (empty !== 4'hF || full !== 4'h0) begin errors++; $display("FAIL rst_flags empty %b full %b want 1111 0000", empty, full); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int v = 0; v < 4; v++) begin
            in_vc = 2'(v);
            #1;
            checks++; if (in_miso.TREADY !== 1'b1) begin errors++; $display("FAIL rst_tready vc%0d got %b want 1", v, in_miso.TREADY); end
        end
    endtask

    // The egress stage absorbs the first beat, so 17 writes are needed to fill VC0.
    task automatic test_fill();
        out_miso.TREADY = 1'b0;
        q.delete();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'd0, 32'(i), (i == 16));
            tick();
            if (i == 15) begin
                checks++; if (level[0] !== 5'd15 || full[0] !== 1'b0) begin errors++; $display("FAIL fill_15 level %0d full %b want 15 0", level[0], full[0]); end
            end
        end
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        checks++; if (level[0] !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", level[0]); end
        checks++; if (full[0] !== 1'b1 || empty[0] !== 1'b0) begin errors++; $display("FAIL fill_flags full %b empty %b want 1 0", full[0], empty[0]); end
        checks++; if (out_mosi.TVALID !== 1'b1 || out_mosi.data.TDATA !== 32'd0) begin errors++; $display("FAIL fill_stage vld %b data %h want 1 0", out_mosi.TVALID, out_mosi.data.TDATA); end
        in_vc = 2'd0;
        #1;
        checks++; if (in_miso.TREADY !== 1'b0) begin errors++; $display("FAIL fill_tready_vc0 got %b want 0", in_miso.TREADY); end
        in_vc = 2'd1;
        #1;
        checks++; if (in_miso.TREADY !== 1'b1) begin errors++; $display("FAIL fill_tready_vc1 got %b want 1", in_miso.TREADY); end
        out_miso.TREADY = 1'b1;
        for (int n = 0; n < 40 && q.size() < 17; n++) tick();
        checks++; if (q.size() != 17) begin errors++; $display("FAIL fill_drain_count got %0d want 17", q.size()); end
        for (int i = 0; i < q.size(); i++) begin
            checks++; if (q[i].vc !== 2'd0 || q[i].d !== 32'(i)) begin errors++; $display("FAIL fill_order[%0d] vc %0d data %h want 0 %h", i, q[i].vc, q[i].d, i); end
        end
        checks++; if (out_mosi.TVALID !== 1'b0 || empty !== 4'hF) begin errors++; $display("FAIL fill_drained vld %b empty %b want 0 1111", out_mosi.TVALID, empty); end
    endtask

    task automatic test_latency();
        out_miso.TREADY = 1'b0;
        q.delete();
        drive(1'b1, 2'd2, 32'hA5, 1'b1);
        tick();
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        checks++; if (out_mosi.TVALID !== 1'b0) begin errors++; $display("FAIL lat_edge1 vld got %b want 0", out_mosi.TVALID); end
        tick();
        checks++; if (out_mosi.TVALID !== 1'b1 || out_mosi.data.TDATA !== 32'hA5 || out_vc !== 2'd2)
            begin errors++; $display("FAIL lat_edge2 vld %b data %h vc %0d want 1 a5 2", out_mosi.TVALID, out_mosi.data.TDATA, out_vc); end
        out_miso.TREADY = 1'b1;
        tick();
        checks++; if (q.size() != 1 || out_mosi.TVALID !== 1'b0) begin errors++; $display("FAIL lat_accept count %0d vld %b want 1 0", q.size(), out_mosi.TVALID); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ev;
        logic [31:0] ed;
        out_miso.TREADY = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 2'd0, 32'h10 + 32'(i), (i == 3)); tick(); end
        for (int i = 0; i < 4; i++) begin drive(1'b1, 2'd1, 32'h20 + 32'(i), (i == 3)); tick(); end
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        out_miso.TREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ev = (i < 4) ? 2'd0 : 2'd1;
            ed = (i < 4) ? 32'h10 + 32'(i) : 32'h20 + 32'(i - 4);
            checks++; if (out_mosi.TVALID !== 1'b1 || out_vc !== ev || out_mosi.data.TDATA !== ed)
                begin errors++; $display("FAIL b2b[%0d] vld %b vc %0d data %h want 1 %0d %h", i, out_mosi.TVALID, out_vc, out_mosi.data.TDATA, ev, ed); end
            tick();
        end
        checks++; if (out_mosi.TVALID !== 1'b0 || q.size() != 8) begin errors++; $display("FAIL b2b_end vld %b count %0d want 0 8", out_mosi.TVALID, q.size()); end
    endtask

    task automatic test_lock();
        logic [1:0]  ev;
        logic [31:0] ed;
        out_miso.TREADY = 1'b1;
        q.delete();
        drive(1'b1, 2'd0, 32'h30, 1'b0); tick();
        drive(1'b1, 2'd0, 32'h31, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 2'd1, 32'h40 + 32'(i), (i == 3)); tick(); end
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        repeat (5) tick();
        checks++; if (out_mosi.TVALID !== 1'b0 || level[1] !== 5'd4) begin errors++; $display("FAIL lock_hold vld %b level1 %0d want 0 4", out_mosi.TVALID, level[1]); end
        drive(1'b1, 2'd0, 32'h32, 1'b0); tick();
        drive(1'b1, 2'd0, 32'h33, 1'b1); tick();
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        for (int n = 0; n < 30 && q.size() < 8; n++) tick();
        checks++; if (q.size() != 8) begin errors++; $display("FAIL lock_count got %0d want 8", q.size()); end
        for (int i = 0; i < q.size(); i++) begin
            ev = (i < 4) ? 2'd0 : 2'd1;
            ed = (i < 4) ? 32'h30 + 32'(i) : 32'h40 + 32'(i - 4);
            checks++; if (q[i].vc !== ev || q[i].d !== ed) begin errors++; $display("FAIL lock_order[%0d] vc %0d data %h want %0d %h", i, q[i].vc, q[i].d, ev, ed); end
        end
    endtask

    // Egress ready alternates; on ready edges a push and a pop coincide and the level holds.
    task automatic test_stall();
        logic [4:0]  exp_lvl;
        logic [31:0] held;
        out_miso.TREADY = 1'b1;
        q.delete();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'd3, 32'h50 + 32'(i), (i == 11));
            out_miso.TREADY = (i % 2 == 0);
            held = out_mosi.data.TDATA;
            tick();
            exp_lvl = (i <= 1) ? 5'd1 : 5'(1 + (i - 1) / 2);
            checks++; if (level[3] !== exp_lvl) begin errors++; $display("FAIL stall_level[%0d] got %0d want %0d", i, level[3], exp_lvl); end
            if (i >= 1) begin
                checks++; if (out_mosi.TVALID !== 1'b1 || out_mosi.data.TDATA !== 32'h50 + 32'(i / 2))
                    begin errors++; $display("FAIL stall_stage[%0d] vld %b data %h want 1 %h", i, out_mosi.TVALID, out_mosi.data.TDATA, 32'h50 + 32'(i / 2)); end
            end
            if (i >= 3 && (i % 2 == 1)) begin
                checks++; if (out_mosi.data.TDATA !== held) begin errors++; $display("FAIL stall_hold[%0d] got %h want %h", i, out_mosi.data.TDATA, held); end
            end
        end
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        for (int n = 0; n < 60 && q.size() < 12; n++) begin
            out_miso.TREADY = (n % 2 == 0);
            tick();
        end
        checks++; if (q.size() != 12) begin errors++; $display("FAIL stall_count got %0d want 12", q.size()); end
        for (int i = 0; i < q.size(); i++) begin
            checks++; if (q[i].vc !== 2'd3 || q[i].d !== 32'h50 + 32'(i)) begin errors++; $display("FAIL stall_order[%0d] vc %0d data %h want 3 %h", i, q[i].vc, q[i].d, 32'h50 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        out_miso.TREADY = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) begin drive(1'b1, 2'd0, 32'h60 + 32'(i), 1'b0); tick(); end
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        checks++; if (level[0] !== 5'd4 || out_mosi.TVALID !== 1'b1) begin errors++; $display("FAIL rmid_pre level0 %0d vld %b want 4 1", level[0], out_mosi.TVALID); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_mosi.TVALID !== 1'b0 || out_vc !== 2'd0) begin errors++; $display("FAIL rmid_out vld %b vc %0d want 0 0", out_mosi.TVALID, out_vc); end
        checks++; if (level !== '0 || empty !== 4'hF || full !== 4'h0) begin errors++; $display("FAIL rmid_state level %h empty %b full %b want 0 1111 0000", level, empty, full); end
        @(negedge clk);
        rst = 1'b0;
        out_miso.TREADY = 1'b1;
        drive(1'b1, 2'd1, 32'h77, 1'b1);
        tick();
        drive(1'b0, 2'd0, 32'd0, 1'b0);
        for (int n = 0; n < 10 && q.size() < 1; n++) tick();
        checks++; if (q.size() != 1) begin errors++; $display("FAIL rmid_after count %0d want 1", q.size()); end
        else begin
            checks++; if (q[0].vc !== 2'd1 || q[0].d !== 32'h77) begin errors++; $display("FAIL rmid_beat vc %0d data %h want 1 77", q[0].vc, q[0].d); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_latency();
        test_back_to_back();
        test_lock();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
